// File: rtl/param_cache_ctrl_if.sv
// CPU load/store port and block-wide memory port of the cache controller.
// slave is the controller's view; master is the CPU/memory side.
interface param_cache_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int WORDS  = 4
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_W-1:0]     cpu_addr;
  logic [31:0]           cpu_wdata;
  logic                  cpu_ready;
  logic [31:0]           cpu_rdata;
  logic                  cpu_hit;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [32*WORDS-1:0]   mem_wdata;
  logic                  mem_ack;
  logic [32*WORDS-1:0]   mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_ready, cpu_rdata, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_ready, cpu_rdata, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/param_cache_ctrl.sv
// Set-associative (1/2-way) cache controller with LRU replacement and
// write-back or write-through policy, both write-allocate.
module param_cache_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int SETS       = 2,
  parameter int WORDS      = 4,
  parameter int WAYS       = 2,
  parameter bit WRITE_BACK = 1'b1
) (
  input logic clk,
  input logic rst_n,
  param_cache_ctrl_if.slave bus
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

  typedef logic [WORDS-1:0][31:0] block_t;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-3:0] wordAddr;
    logic [31:0]       wdata;
  } cpuReq_t;
  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, WTHRU} state_t;

  state_t          state, nextState;
  cpuReq_t         reqQ;
  logic            firstHitQ, gapQ, wayQ;
  logic [31:0]     rdataQ;
  logic [TAG_W-1:0] tagArr [WAYS][SETS];
  block_t          dataArr [WAYS][SETS];
  logic [WAYS-1:0] validQ [SETS];
  logic [WAYS-1:0] dirtyQ [SETS];
  logic [SETS-1:0] lruQ;

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  assign tag = reqQ.wordAddr[ADDR_W-3 -: TAG_W];
  assign idx = reqQ.wordAddr[OFF_W +: IDX_W];
  assign off = reqQ.wordAddr[OFF_W-1:0];

  logic [WAYS-1:0] hitVec;
  logic            hit, hitWay, victim, victimDirty;
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign hitVec[w] = validQ[idx][w] && (tagArr[w][idx] == tag);
  end
  assign hit    = |hitVec;
  assign hitWay = (WAYS == 2) && hitVec[WAYS-1];

  // Victim: lowest invalid way first, otherwise the LRU way.
  always_comb begin
    victim = 1'b0;
    if (WAYS == 2) begin
      if (!validQ[idx][0])           victim = 1'b0;
      else if (!validQ[idx][WAYS-1]) victim = 1'b1;
      else                           victim = lruQ[idx];
    end
  end
  assign victimDirty = validQ[idx][victim] && dirtyQ[idx][victim];

  logic memState, ackOk;
  assign memState = (state == WRITEBACK) || (state == ALLOCATE) || (state == WTHRU);
  // gapQ forces mem_req low for one cycle after every completed transfer.
  assign bus.mem_req = memState && !gapQ;
  assign ackOk       = bus.mem_ack && bus.mem_req;

  logic cpuReady, rdHit, fillEn, wrWordEn, setDirty, clrDirty, touch, miss;
  always_comb begin
    nextState = state;
    cpuReady  = 1'b0;
    rdHit     = 1'b0;
    fillEn    = 1'b0;
    wrWordEn  = 1'b0;
    setDirty  = 1'b0;
    clrDirty  = 1'b0;
    touch     = 1'b0;
    miss      = 1'b0;
    unique case (state)
      IDLE: if (bus.cpu_req) nextState = COMPARE;
      COMPARE: begin
        if (hit) begin
          touch = 1'b1;
          if (reqQ.we) begin
            wrWordEn = 1'b1;
            if (WRITE_BACK) begin
              setDirty  = 1'b1;
              cpuReady  = 1'b1;
              nextState = IDLE;
            end else begin
              nextState = WTHRU;
            end
          end else begin
            rdHit     = 1'b1;
            cpuReady  = 1'b1;
            nextState = IDLE;
          end
        end else begin
          miss      = 1'b1;
          nextState = (WRITE_BACK && victimDirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: if (ackOk) begin
        clrDirty  = 1'b1;
        nextState = ALLOCATE;
      end
      ALLOCATE: if (ackOk) begin
        fillEn    = 1'b1;
        nextState = COMPARE;
      end
      WTHRU: if (ackOk) begin
        cpuReady  = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      reqQ      <= '0;
      firstHitQ <= 1'b0;
      gapQ      <= 1'b0;
      wayQ      <= 1'b0;
      rdataQ    <= '0;
      validQ    <= '{default: '0};
      dirtyQ    <= '{default: '0};
      lruQ      <= '0;
    end else begin
      state <= nextState;
      gapQ  <= ackOk;
      if (state == IDLE && bus.cpu_req) begin
        reqQ      <= '{we: bus.cpu_we, wordAddr: bus.cpu_addr[ADDR_W-1:2], wdata: bus.cpu_wdata};
        firstHitQ <= 1'b1;
      end
      if (state == COMPARE) wayQ <= hit ? hitWay : victim;
      if (miss)     firstHitQ <= 1'b0;
      if (rdHit)    rdataQ <= dataArr[hitWay][idx][off];
      if (setDirty) dirtyQ[idx][hitWay] <= 1'b1;
      if (clrDirty) dirtyQ[idx][wayQ] <= 1'b0;
      if (fillEn) begin
        validQ[idx][wayQ] <= 1'b1;
        dirtyQ[idx][wayQ] <= 1'b0;
      end
      if (touch && WAYS == 2) lruQ[idx] <= ~hitWay;
    end
  end

  // Tag and data storage carry no reset; validQ guards them.
  always_ff @(posedge clk) begin
    if (fillEn) begin
      dataArr[wayQ][idx] <= bus.mem_rdata;
      tagArr[wayQ][idx]  <= tag;
    end
    if (wrWordEn) dataArr[hitWay][idx][off] <= reqQ.wdata;
  end

  assign bus.cpu_ready = cpuReady;
  assign bus.cpu_hit   = cpuReady & firstHitQ;
  assign bus.cpu_rdata = rdHit ? dataArr[hitWay][idx][off] : rdataQ;
  assign bus.mem_we    = (state == WRITEBACK) || (state == WTHRU);
  assign bus.mem_wdata = bus.mem_we ? dataArr[wayQ][idx] : '0;

  always_comb begin
    bus.mem_addr = '0;
    if (state == WRITEBACK)
      bus.mem_addr = {tagArr[wayQ][idx], idx, {(OFF_W+2){1'b0}}};
    else if (state == ALLOCATE || state == WTHRU)
      bus.mem_addr = {tag, idx, {(OFF_W+2){1'b0}}};
  end

  logic unusedBits;
  assign unusedBits = ^bus.cpu_addr[1:0];
endmodule

// File: tb/tb_param_cache_ctrl.sv
// Drives three cache configurations with directed and random accesses and
// checks them against a timestamp-LRU cache model and a block memory model.
module tb_param_cache_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int sel = 0;
  logic cpuReq = 0, cpuWe = 0, memAck = 0;
  logic [9:0]   cpuAddr = '0;
  logic [31:0]  cpuWdata = '0;
  logic [127:0] memRdata = '0;
  int total = 0, bad = 0;

  param_cache_ctrl_if #(.ADDR_W(10), .WORDS(4)) ifA();
  param_cache_ctrl_if #(.ADDR_W(10), .WORDS(4)) ifB();
  param_cache_ctrl_if #(.ADDR_W(10), .WORDS(2)) ifC();

  param_cache_ctrl #(.ADDR_W(10), .SETS(2), .WORDS(4), .WAYS(2), .WRITE_BACK(1'b1))
    dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
  param_cache_ctrl #(.ADDR_W(10), .SETS(2), .WORDS(4), .WAYS(2), .WRITE_BACK(1'b0))
    dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));
  param_cache_ctrl #(.ADDR_W(10), .SETS(4), .WORDS(2), .WAYS(1), .WRITE_BACK(1'b1))
    dutC (.clk(clk), .rst_n(rst_n), .bus(ifC));

  assign ifA.cpu_req = cpuReq && (sel == 0);
  assign ifB.cpu_req = cpuReq && (sel == 1);
  assign ifC.cpu_req = cpuReq && (sel == 2);
  assign ifA.mem_ack = memAck && (sel == 0);
  assign ifB.mem_ack = memAck && (sel == 1);
  assign ifC.mem_ack = memAck && (sel == 2);
  assign ifA.cpu_we = cpuWe;      assign ifB.cpu_we = cpuWe;      assign ifC.cpu_we = cpuWe;
  assign ifA.cpu_addr = cpuAddr;  assign ifB.cpu_addr = cpuAddr;  assign ifC.cpu_addr = cpuAddr;
  assign ifA.cpu_wdata = cpuWdata; assign ifB.cpu_wdata = cpuWdata; assign ifC.cpu_wdata = cpuWdata;
  assign ifA.mem_rdata = memRdata; assign ifB.mem_rdata = memRdata; assign ifC.mem_rdata = memRdata[63:0];

  logic oReady, oHit, oMreq, oMwe;
  logic [31:0]  oRdata;
  logic [9:0]   oMaddr;
  logic [127:0] oMwdata;
  always_comb begin
    oReady = ifA.cpu_ready; oHit = ifA.cpu_hit; oRdata = ifA.cpu_rdata;
    oMreq = ifA.mem_req; oMwe = ifA.mem_we; oMaddr = ifA.mem_addr; oMwdata = ifA.mem_wdata;
    if (sel == 1) begin
      oReady = ifB.cpu_ready; oHit = ifB.cpu_hit; oRdata = ifB.cpu_rdata;
      oMreq = ifB.mem_req; oMwe = ifB.mem_we; oMaddr = ifB.mem_addr; oMwdata = ifB.mem_wdata;
    end else if (sel == 2) begin
      oReady = ifC.cpu_ready; oHit = ifC.cpu_hit; oRdata = ifC.cpu_rdata;
      oMreq = ifC.mem_req; oMwe = ifC.mem_we; oMaddr = ifC.mem_addr; oMwdata = {64'b0, ifC.mem_wdata};
    end
  end

  // Configuration of the active DUT, as seen by the model.
  int cfgWays, cfgSets, cfgWords;
  bit cfgWb;

  // Main memory as seen by the DUT (env) and as predicted (model).
  logic [31:0] envMem [256];
  logic [31:0] modelMem [256];

  // Cache model: per set/slot tag, valid, dirty, last-use timestamp, data.
  int          mTag [4][2];
  bit          mValid [4][2];
  bit          mDirty [4][2];
  int          mUse [4][2];
  logic [127:0] mData [4][2];
  int          stamp;

  typedef struct packed { logic we; logic [9:0] addr; logic [127:0] data; } memTx_t;
  memTx_t expQ[$];
  memTx_t obsQ[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelClear();
    stamp = 0;
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 2; w++) begin
        mValid[s][w] = 0; mDirty[s][w] = 0; mUse[s][w] = 0; mTag[s][w] = 0; mData[s][w] = '0;
      end
  endtask

  task automatic modelAccess(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                             output logic expHit, output logic [31:0] expRd);
    int wa, off, blk, idx, tg, w, v;
    memTx_t tx;
    wa = int'(addr) >> 2;
    off = wa % cfgWords; blk = wa / cfgWords;
    idx = blk % cfgSets; tg = blk / cfgSets;
    w = -1;
    for (int i = 0; i < cfgWays; i++) if (mValid[idx][i] && mTag[idx][i] == tg) w = i;
    expHit = (w >= 0);
    if (w < 0) begin
      v = -1;
      for (int i = 0; i < cfgWays; i++) if (!mValid[idx][i] && v < 0) v = i;
      if (v < 0) begin
        v = 0;
        for (int i = 1; i < cfgWays; i++) if (mUse[idx][i] < mUse[idx][v]) v = i;
        if (mDirty[idx][v]) begin
          tx.we = 1'b1; tx.addr = 10'((mTag[idx][v] * cfgSets + idx) * cfgWords * 4);
          tx.data = mData[idx][v];
          expQ.push_back(tx);
          for (int k = 0; k < cfgWords; k++)
            modelMem[(mTag[idx][v] * cfgSets + idx) * cfgWords + k] = mData[idx][v][32*k +: 32];
        end
      end
      tx.we = 1'b0; tx.addr = 10'(blk * cfgWords * 4); tx.data = '0;
      expQ.push_back(tx);
      mData[idx][v] = '0;
      for (int k = 0; k < cfgWords; k++) mData[idx][v][32*k +: 32] = modelMem[blk * cfgWords + k];
      mValid[idx][v] = 1; mDirty[idx][v] = 0; mTag[idx][v] = tg;
      w = v;
    end
    stamp++;
    mUse[idx][w] = stamp;
    if (we) begin
      mData[idx][w][32*off +: 32] = wd;
      if (cfgWb) mDirty[idx][w] = 1;
      else begin
        tx.we = 1'b1; tx.addr = 10'(blk * cfgWords * 4); tx.data = mData[idx][w];
        expQ.push_back(tx);
        for (int k = 0; k < cfgWords; k++) modelMem[blk * cfgWords + k] = mData[idx][w][32*k +: 32];
      end
    end
    expRd = mData[idx][w][32*off +: 32];
  endtask

  task automatic resetAll(input int s);
    sel = s;
    cfgWays  = (s == 2) ? 1 : 2;
    cfgSets  = (s == 2) ? 4 : 2;
    cfgWords = (s == 2) ? 2 : 4;
    cfgWb    = (s != 1);
    rst_n = 1'b0; cpuReq = 0; cpuWe = 0; cpuAddr = '0; cpuWdata = '0; memAck = 0; memRdata = '0;
    for (int i = 0; i < 256; i++) begin
      envMem[i] = 32'(32'h11 * (i + 1));
      modelMem[i] = 32'(32'h11 * (i + 1));
    end
    modelClear();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctl", {oReady, oHit, oMreq, oMwe, oRdata, oMaddr}, '0);
    chk("reset_wdata", oMwdata, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One CPU access with a responsive memory; lat < 0 picks random latency.
  task automatic doAccess(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                          input int lat, output logic [31:0] gotRd, output logic gotHit);
    logic expHit, doAck, inTx, justAcked, done, stable;
    logic [31:0] expRd;
    logic [138:0] curBits;
    int cyc, wcnt, tgt, base;
    memTx_t tx;
    expQ.delete(); obsQ.delete();
    modelAccess(we, addr, wd, expHit, expRd);
    @(negedge clk);
    cpuReq = 1; cpuWe = we; cpuAddr = addr; cpuWdata = wd;
    cyc = 0; wcnt = 0; tgt = 0; inTx = 0; justAcked = 0; done = 0; stable = 1;
    curBits = '0; gotRd = '0; gotHit = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      memAck = 0; doAck = 0; cyc++;
      if (justAcked) begin
        chk("mreq_drop", oMreq, 0);
        justAcked = 0;
      end else if (inTx) begin
        if (!oMreq || {oMwe, oMaddr, oMwdata} !== curBits) stable = 0;
        wcnt++;
        if (wcnt >= tgt) doAck = 1;
      end else if (oMreq) begin
        inTx = 1; stable = 1; wcnt = 0;
        tgt = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
        curBits = {oMwe, oMaddr, oMwdata};
        tx.we = oMwe; tx.addr = oMaddr; tx.data = oMwdata;
        obsQ.push_back(tx);
        if (tgt == 0) doAck = 1;
      end else if ($urandom_range(0, 3) == 0) begin
        memAck = 1;
      end
      if (doAck) begin
        base = int'(oMaddr) >> 2;
        memRdata = '0;
        for (int k = 0; k < cfgWords; k++) begin
          if (oMwe) envMem[base + k] = oMwdata[32*k +: 32];
          else memRdata[32*k +: 32] = envMem[base + k];
        end
        memAck = 1; inTx = 0; justAcked = 1;
        chk("mem_stable", stable, 1);
      end
      #1;
      if (oReady) begin
        done = 1; gotRd = oRdata; gotHit = oHit;
      end
    end
    cpuReq = 0;
    chk("timeout", done, 1);
    chk("hit", gotHit, expHit);
    if (!we) chk("rdata", gotRd, expRd);
    if (expHit && (!we || cfgWb)) chk("hit_latency", cyc, 1);
    chk("tx_count", obsQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      chk("tx_we", obsQ[i].we, expQ[i].we);
      chk("tx_addr", obsQ[i].addr, expQ[i].addr);
      if (expQ[i].we) chk("tx_data", obsQ[i].data, expQ[i].data);
    end
    @(negedge clk);
    memAck = 0;
  endtask

  task automatic randomRun(input int n);
    logic [31:0] gr;
    logic gh;
    for (int i = 0; i < n; i++)
      doAccess(1'($urandom_range(0, 1)), 10'($urandom_range(0, 63) << 2), $urandom, -1, gr, gh);
  endtask

  initial begin
    logic [31:0] gr;
    logic gh, stable;
    logic [10:0] holdBits;
    int waitCnt;

    // Write-back, 2-way: fill, hits, dirty-victim writeback.
    resetAll(0);
    doAccess(0, 10'h000, '0, 3, gr, gh);
    chk("p1_fill_rd", gr, 32'h11);
    chk("p1_fill_hit", gh, 0);
    if (obsQ.size() == 1) chk("p1_fill_addr", {obsQ[0].we, obsQ[0].addr}, 11'h000);
    doAccess(0, 10'h004, '0, -1, gr, gh);
    chk("p1_hit_rd", gr, 32'h22);
    chk("p1_hit", gh, 1);
    doAccess(1, 10'h008, 32'hDEADBEEF, -1, gr, gh);
    chk("p2_wr_notx", obsQ.size(), 0);
    doAccess(0, 10'h008, '0, -1, gr, gh);
    chk("p2_rd", gr, 32'hDEADBEEF);
    doAccess(1, 10'h000, 32'h12345678, -1, gr, gh);
    doAccess(0, 10'h020, '0, -1, gr, gh);
    doAccess(0, 10'h040, '0, -1, gr, gh);
    chk("p3_hit", gh, 0);
    if (obsQ.size() == 2) begin
      chk("p3_wb", {obsQ[0].we, obsQ[0].addr}, 11'h400);
      chk("p3_wb_word2", obsQ[0].data[95:64], 32'hDEADBEEF);
      chk("p3_alloc", {obsQ[1].we, obsQ[1].addr}, 11'h040);
    end
    randomRun(40);

    // Write-through.
    resetAll(1);
    doAccess(0, 10'h000, '0, -1, gr, gh);
    doAccess(1, 10'h004, 32'hA5A5A5A5, 4, gr, gh);
    chk("p4_hit", gh, 1);
    if (obsQ.size() == 1)
      chk("p4_wt_blk", {obsQ[0].we, obsQ[0].addr, obsQ[0].data},
          {1'b1, 10'h000, 32'h44, 32'h33, 32'hA5A5A5A5, 32'h11});
    randomRun(40);

    // Direct-mapped, 4 sets of 2 words.
    resetAll(2);
    doAccess(0, 10'h000, '0, -1, gr, gh);
    doAccess(0, 10'h020, '0, -1, gr, gh);
    chk("p6_evict_hit", gh, 0);
    doAccess(0, 10'h000, '0, -1, gr, gh);
    chk("p6_remiss_hit", gh, 0);
    randomRun(40);

    // Stalled allocate, then reset in the middle of it.
    resetAll(0);
    doAccess(0, 10'h000, '0, -1, gr, gh);
    @(negedge clk);
    cpuReq = 1; cpuWe = 0; cpuAddr = 10'h100;
    waitCnt = 0;
    #1;
    while (!oMreq && waitCnt < 20) begin
      @(negedge clk); #1; waitCnt++;
    end
    chk("p5_alloc_seen", oMreq, 1);
    holdBits = {oMwe, oMaddr};
    chk("p5_alloc_addr", holdBits, 11'h100);
    stable = 1;
    repeat (10) begin
      @(negedge clk); #1;
      if ({oMwe, oMaddr} !== holdBits || oReady || !oMreq) stable = 0;
    end
    chk("p5_hold", stable, 1);
    #2 rst_n = 1'b0;
    #1 chk("p5_rst_mreq", oMreq, 0);
    cpuReq = 0;
    @(negedge clk);
    rst_n = 1'b1;
    modelClear();
    doAccess(0, 10'h000, '0, -1, gr, gh);
    chk("p5_after_rst_hit", gh, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/param_cache_ctrl.md
Name: param_cache_ctrl

Overview:
Clocked, parametrised set-associative cache controller with an FSM, replacing the combinational cache/memory pairing in the CPU memory path. Sits between a CPU load/store port (req/ready handshake) and a block-wide main memory with variable latency (req/ack handshake). Supports 1- or 2-way associativity, configurable set count and block size, LRU replacement, and write-back or write-through modes.

Parameters:
ADDR_W, 10, byte address width.
SETS, 2, number of sets; power of two, >=2.
WORDS, 4, 32-bit words per block; power of two, >=2.
WAYS, 2, associativity; 1 or 2.
WRITE_BACK, 1, 1 = write-back with dirty bits; 0 = write-through; both write-allocate.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
cpu_req  in  1  access request; sampled only in IDLE.
cpu_we  in  1  1 = write, 0 = read.
cpu_addr  in  ADDR_W  byte address: [1:0] byte, then word offset log2(WORDS), index log2(SETS), remainder tag.
cpu_wdata  in  32  store word.
cpu_ready  out  1  one-cycle completion pulse.
cpu_rdata  out  32  load word; valid when cpu_ready is high.
cpu_hit  out  1  1 if the completed access hit on first lookup; valid with cpu_ready.
mem_req  out  1  memory request, level.
mem_we  out  1  1 = block write, 0 = block read.
mem_addr  out  ADDR_W  block-aligned address; low 2+log2(WORDS) bits are zero.
mem_wdata  out  32*WORDS  block write data, word 0 in bits [31:0].
mem_ack  in  1  one-cycle completion; mem_rdata valid in the same cycle.
mem_rdata  in  32*WORDS  block read data.

Behaviour:
- Reset (async): state IDLE; all valid, dirty and LRU bits cleared; every output 0. Data/tag arrays are not reset. Reset mid-transaction aborts it: mem_req drops immediately and the request is lost.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE, WTHRU.
- IDLE: on cpu_req=1, latch addr/we/wdata; set first_hit=1; go COMPARE.
- COMPARE: tag match on any valid way = hit.
  - Read hit: drive cpu_rdata, pulse cpu_ready, cpu_hit=first_hit, update LRU, go IDLE. Latency is 1 cycle after the accept edge.
  - Write hit, WRITE_BACK=1: write the word, set dirty, pulse cpu_ready, update LRU, go IDLE.
  - Write hit, WRITE_BACK=0: write the word, go WTHRU.
  - Miss: clear first_hit and choose a victim. Victim priority: lowest-numbered invalid way, else the LRU way. If the victim is valid and dirty (WRITE_BACK=1 only), go WRITEBACK; otherwise go ALLOCATE.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata=victim block. On mem_ack, clear dirty and go ALLOCATE.
- ALLOCATE: mem_req=1, mem_we=0, mem_addr={tag, index, 0}. On mem_ack, fill the victim way, set valid, clear dirty, write the tag, and go COMPARE, which then hits.
- WTHRU: mem_req=1, mem_we=1, with the updated block of the hit way. On mem_ack, pulse cpu_ready with cpu_hit=first_hit and go IDLE.
- mem_req, mem_we, mem_addr and mem_wdata are held stable until the cycle mem_ack is sampled high. mem_req drops the cycle after that. mem_ack while mem_req=0 is ignored.
- LRU: one bit per set; any access to way w sets LRU to the other way. With WAYS=1 there is no LRU and way 0 is always the victim.
- cpu_rdata holds its last value between responses. cpu_req outside IDLE is ignored, and the CPU holds the request until cpu_ready.
- Minimum inter-request gap is one cycle, since cpu_ready returns the FSM to IDLE.

Test Plan:
1. Defaults. After reset, read 0x000; memory acks 3 cycles after mem_req with words {0x11,0x22,0x33,0x44} -> mem_addr=0x000, mem_we=0; cpu_ready with cpu_hit=0, cpu_rdata=0x11. Then read 0x004 -> cpu_ready 1 cycle after accept, cpu_hit=1, rdata=0x22, mem_req stays 0.
2. Write 0x008 with 0xDEADBEEF after the fill -> hit with no memory traffic. Reading 0x008 returns 0xDEADBEEF.
3. Index-0 conflict: write 0x000 (dirty), read 0x020, read 0x040 -> 0x000 is LRU and dirty. Expect a mem write at 0x000 with word2=0xDEADBEEF, then a mem read at 0x040; cpu_hit=0.
4. WRITE_BACK=0: write hit at 0x004 with 0xA5A5A5A5 -> mem_we=1 write of the full block at 0x000. cpu_ready comes only after mem_ack, with cpu_hit=1.
5. Withhold mem_ack for 10 cycles during ALLOCATE -> mem_addr and mem_we stay constant and cpu_ready stays 0. Then drop rst_n mid-wait -> mem_req=0 immediately; after release, a read of the previously cached 0x000 misses.
6. WAYS=1, SETS=4, WORDS=2: reads of 0x000 then 0x020 (same index) -> the second read evicts the first. A repeat read of 0x000 misses again with cpu_hit=0.
